// File: rtl/count_stream_checker.sv
// Receive-side checker for a free-running 8-bit count stream: locks on, counts wraps and errors.
// Optional build macro GRAY_DECODE_EN: count_in is Gray-coded and decoded to binary before all compares.
module count_stream_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned MAX_ERR    = 3,
    parameter bit          ALLOW_HOLD = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] count_in,
    input  logic       count_vld,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_cnt,
    output logic [7:0] wrap_cnt,
    output logic [7:0] last_val,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        TRACK = 2'd2,
        LOST  = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] ERR_N  = 4'(MAX_ERR);

    state_t     state_q, state_d;
    logic [7:0] last_val_q, last_val_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] wrap_cnt_q, wrap_cnt_d;
    logic [3:0] good_run_q, good_run_d;
    logic [3:0] bad_run_q, bad_run_d;
    logic       err_pulse_q, err_pulse_d;
    logic [7:0] sample;
    logic       is_good, is_hold, is_bad;

`ifdef GRAY_DECODE_EN
    function automatic logic [7:0] gray_to_bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign sample = gray_to_bin(count_in);
`else
    assign sample = count_in;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 8'd1;
    endfunction

    // 8-bit compare so 0xFF -> 0x00 counts as a good increment
    assign is_good = (sample == last_val_q + 8'd1);
    assign is_hold = (sample == last_val_q);
    assign is_bad  = !is_good && !(is_hold && ALLOW_HOLD);

    always_comb begin
        state_d     = state_q;
        last_val_d  = last_val_q;
        err_cnt_d   = err_cnt_q;
        wrap_cnt_d  = wrap_cnt_q;
        good_run_d  = good_run_q;
        bad_run_d   = bad_run_q;
        err_pulse_d = 1'b0;
        if (count_vld) begin
            case (state_q)
                IDLE, LOST: begin
                    last_val_d = sample;
                    good_run_d = 4'd0;
                    state_d    = LOCK;
                end
                LOCK: begin
                    if (is_good) begin
                        last_val_d = sample;
                        good_run_d = good_run_q + 4'd1;
                        if (good_run_d == LOCK_N) begin
                            state_d   = TRACK;
                            bad_run_d = 4'd0;
                        end
                    end else if (is_bad) begin
                        last_val_d = sample;
                        good_run_d = 4'd0;
                    end
                end
                TRACK: begin
                    if (is_good) begin
                        last_val_d = sample;
                        bad_run_d  = 4'd0;
                        if (last_val_q == 8'hFF) begin
                            wrap_cnt_d = sat_inc(wrap_cnt_q);
                        end
                    end else if (is_bad) begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = sat_inc(err_cnt_q);
                        last_val_d  = sample;
                        bad_run_d   = bad_run_q + 4'd1;
                        if (bad_run_d == ERR_N) begin
                            state_d = LOST;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_val_q  <= 8'd0;
            err_cnt_q   <= 8'd0;
            wrap_cnt_q  <= 8'd0;
            good_run_q  <= 4'd0;
            bad_run_q   <= 4'd0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_val_q  <= last_val_d;
            err_cnt_q   <= err_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
            good_run_q  <= good_run_d;
            bad_run_q   <= bad_run_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = (state_q == TRACK);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign wrap_cnt  = wrap_cnt_q;
    assign last_val  = last_val_q;
    assign state_o   = state_q;

endmodule

// File: doc/count_stream_checker.md
Name: count_stream_checker

Overview:
Receive-side checker for the free-running 8-bit counter stream that the blink/counter tile drives on its output pins. It samples an incoming count bus on a qualifier strobe and checks that each new value is the previous value +1, modulo 256. It locks onto the stream, counts wraps and errors, and flags loss of lock. It sits on the bench/companion tile that consumes the counter's pins, so the counter can be verified in silicon.

Parameters:
LOCK_COUNT, 4, consecutive correct increments required to enter TRACK (1..15)
MAX_ERR, 3, consecutive bad samples in TRACK that force LOST (1..15)
ALLOW_HOLD, 1, 1 = a sample equal to the previous value is legal (no error, no advance); 0 = a repeat is an error

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
count_in  in  8  incoming counter value, already in the clk domain
count_vld  in  1  sample strobe; count_in is valid when high
locked  out  1  high in TRACK
err_pulse  out  1  one-cycle pulse per bad sample in TRACK
err_cnt  out  8  total bad samples in TRACK, saturates at 255
wrap_cnt  out  8  0xFF->0x00 transitions seen in TRACK, saturates at 255
last_val  out  8  last accepted (decoded) sample
state_o  out  2  current state: 0 IDLE, 1 LOCK, 2 TRACK, 3 LOST

Behaviour:
- Reset (rst high at a clk edge) clears everything and the reset takes priority over count_vld: state=IDLE, locked=0, err_pulse=0, err_cnt=0, wrap_cnt=0, last_val=0, and the internal good/bad run counters = 0.
- All outputs are registered. Sample at edge N is reflected in the outputs after edge N; there are no combinational paths from inputs to outputs.
- Definitions for a sample v with previous value p: good when v == p+1 (8-bit wrap, so 0xFF->0x00 is good); hold when v == p; bad otherwise. A hold counts as bad when ALLOW_HOLD=0.
- IDLE: on the first count_vld, last_val<=v, good-run<=0, go to LOCK.
- LOCK:
  - good: last_val<=v, good-run+1; when good-run reaches LOCK_COUNT, go to TRACK and clear bad-run.
  - hold (allowed): no change.
  - bad: last_val<=v, good-run<=0, stay in LOCK. No err_pulse and err_cnt unchanged.
- TRACK:
  - good: last_val<=v, bad-run<=0; if p==0xFF, wrap_cnt+1 (saturating).
  - hold (allowed): no change.
  - bad: err_pulse=1 for one cycle, err_cnt+1 (saturating), last_val<=v, bad-run+1. When bad-run reaches MAX_ERR, go to LOST.
- LOST: locked=0. On the next count_vld, last_val<=v, good-run<=0, go to LOCK. err_cnt and wrap_cnt are retained and cleared only by rst.
- No count_vld: state and outputs hold, and err_pulse=0.
- Saturation: err_cnt and wrap_cnt stick at 0xFF and never wrap.
- Reset mid-stream: the checker returns to IDLE on the same edge, and the next valid sample starts re-acquisition.

Optional Feature:
GRAY_DECODE_EN.
- Defined: count_in is treated as 8-bit Gray code and decoded to binary (b[7]=g[7], b[i]=b[i+1]^g[i]) before all compares. last_val holds the decoded binary value. This lets the transmitter tile export a Gray count that can be safely crossed from its ring-oscillator domain.
- Undefined: count_in is used as plain binary and no decode logic is present.

Test Plan:
- Reset then samples 0x10,0x11,0x12,0x13,0x14 -> state goes IDLE->LOCK->TRACK after the 5th sample; locked=1, last_val=0x14, err_cnt=0.
- Locked at 0xFE, then 0xFF,0x00,0x01 -> wrap_cnt=1, no err_pulse, last_val=0x01.
- TRACK at 0x20, then 0x25 -> err_pulse high exactly one cycle, err_cnt=1; then 0x26 continues good with bad-run cleared and locked still 1.
- TRACK, three consecutive bad samples 0x80,0x90,0xA0 (MAX_ERR=3) -> LOST after the 3rd with locked=0, err_cnt=3. Next sample -> LOCK, and LOCK_COUNT good samples relock with err_cnt still 3.
- Repeat-value handling, TRACK at 0x40 then 0x40:
  - ALLOW_HOLD=1: no error, last_val=0x40.
  - ALLOW_HOLD=0: err_pulse and err_cnt=1.
- Reset mid-TRACK with count_vld high on the same edge -> all outputs zero and state IDLE. Then with GRAY_DECODE_EN, Gray inputs 0x00,0x01,0x03,0x02,0x06 -> lock with last_val=0x04.
